// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter and its shifter.
package shift_pkg;

    localparam int SHIFT_WIDTH = 64;
    localparam int SHIFT_SHW   = 6;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2,
        SH_ROR = 2'd3
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } shift_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan N positions starting at ptr; the first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < int'(N); k++) begin
            idx = PW'((int'(ptr) + int'(k)) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Sequencer sharing one barrel shifter among N_REQ requesters:
// grant in IDLE, let the shifter settle in EXEC, hold the result in RESP.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0][SHW-1:0]   req_shamt,
    input  shift_op_e [N_REQ-1:0]       req_op,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic [WIDTH-1:0]            sh_in,
    output logic [SHW-1:0]              sh_shamt,
    output shift_op_e                   sh_op,
    input  logic [WIDTH-1:0]            sh_result
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    shift_arb_state_e state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready only reflects the grant while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst) begin
            req_ready = grant;
        end
    end

    // Controller FSM with registered shifter operands and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            sh_in     <= '0;
            sh_shamt  <= '0;
            sh_op     <= SH_SLL;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        sh_in    <= req_data[grant_idx];
                        sh_shamt <= req_shamt[grant_idx];
                        sh_op    <= req_op[grant_idx];
                        owner    <= grant_idx;
                        rr_ptr   <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= sh_result;
                    rsp_valid <= N_REQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter with a behavioural shifter attached.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [3:0]            req_valid;
    logic [3:0]            req_ready;
    logic [3:0][63:0]      req_data;
    logic [3:0][5:0]       req_shamt;
    shift_op_e [3:0]       req_op;
    logic [3:0]            rsp_valid;
    logic [3:0]            rsp_ready;
    logic [63:0]           rsp_data;
    logic [63:0]           sh_in;
    logic [5:0]            sh_shamt;
    shift_op_e             sh_op;
    logic [63:0]           sh_result;

    int n_vec  = 0;
    int n_miss = 0;

    shift_arbiter #(
        .N_REQ (4),
        .WIDTH (64),
        .SHW   (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .sh_in     (sh_in),
        .sh_shamt  (sh_shamt),
        .sh_op     (sh_op),
        .sh_result (sh_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shift arithmetic, written straight from the operation names.
    function automatic logic [63:0] shf(input logic [63:0] d, input logic [5:0] s, input shift_op_e op);
        case (op)
            SH_SLL:  return d << s;
            SH_SRL:  return d >> s;
            SH_SRA:  return $signed(d) >>> s;
            default: return (d >> s) | (d << (7'd64 - {1'b0, s}));
        endcase
    endfunction

    // Behavioural shifter that the arbiter drives.
    always_comb sh_result = shf(sh_in, sh_shamt, sh_op);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycles since accept, who owns it, what it computes.
    int          m_since;
    int          m_ptr;
    int          m_owner;
    logic [63:0] m_res;
    int          ncyc = 0;
    int          glog[$];
    int          gcyc[$];

    always @(negedge clk) begin
        logic [3:0] er;
        int         g;
        int         j;
        ncyc++;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_sh_in", sh_in, 0);
            chk("rst_sh_shamt", sh_shamt, 0);
            chk("rst_sh_op", sh_op, SH_SLL);
            m_since = 0;
            m_ptr   = 0;
            m_owner = 0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (req_ready[k]) begin
                    glog.push_back(k);
                    gcyc.push_back(ncyc);
                end
            er = '0;
            g  = -1;
            if (m_since == 0) begin
                for (int k = 0; k < 4; k++) begin
                    j = (m_ptr + k) % 4;
                    if (g < 0 && req_valid[j]) g = j;
                end
                if (g >= 0) er[g] = 1'b1;
                chk("model_req_ready", req_ready, er);
                chk("model_rsp_valid", rsp_valid, 0);
                if (g >= 0) begin
                    m_res   = shf(req_data[g], req_shamt[g], req_op[g]);
                    m_owner = g;
                    m_ptr   = (g + 1) % 4;
                    m_since = 1;
                end
            end else if (m_since == 1) begin
                chk("model_req_ready", req_ready, 0);
                chk("model_rsp_valid", rsp_valid, 0);
                m_since = 2;
            end else begin
                er[m_owner] = 1'b1;
                chk("model_req_ready", req_ready, 0);
                chk("model_rsp_valid", rsp_valid, er);
                chk("model_rsp_data", rsp_data, m_res);
                if (rsp_ready[m_owner]) m_since = 0;
            end
        end
    end

    // Stimulus side: snapshot at negedge, then update inputs just after posedge.
    logic [3:0]  refill = '0;
    logic [3:0]  last_ready;
    logic [3:0]  last_rsp_valid;
    logic [63:0] last_rsp_data;

    task automatic cyc();
        logic [3:0] acc;
        @(negedge clk);
        acc            = req_valid & req_ready;
        last_ready     = req_ready;
        last_rsp_valid = rsp_valid;
        last_rsp_data  = rsp_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (acc[i]) begin
                if (refill[i]) begin
                    req_data[i]  = {$urandom, $urandom};
                    req_shamt[i] = 6'($urandom_range(0, 63));
                    req_op[i]    = shift_op_e'($urandom_range(0, 3));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
    endtask

    task automatic send(input int i, input logic [63:0] d, input logic [5:0] s, input shift_op_e op);
        req_data[i]  = d;
        req_shamt[i] = s;
        req_op[i]    = op;
        req_valid[i] = 1'b1;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((req_valid != 0 || last_rsp_valid != 0 || m_since != 0) && t < 60) begin
            cyc();
            t++;
        end
        chk(nm, t < 60, 1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_shamt = '0;
        req_op    = {SH_SLL, SH_SLL, SH_SLL, SH_SLL};
        rsp_ready = '0;
        last_rsp_valid = '0;
        repeat (3) cyc();
        rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("idle_ready", last_ready, 0);
            chk("idle_rsp_valid", last_rsp_valid, 0);
            chk("idle_rsp_data", last_rsp_data, 0);
        end

        // Single ROR request from requester 2
        rsp_ready = 4'hF;
        send(2, 64'h8000_0000_0000_0001, 6'd4, SH_ROR);
        cyc();
        chk("single_ready", last_ready, 4'b0100);
        cyc();
        chk("single_exec_rsp_valid", last_rsp_valid, 0);
        cyc();
        chk("single_rsp_valid", last_rsp_valid, 4'b0100);
        chk("single_rsp_data", last_rsp_data, 64'h1800_0000_0000_0000);
        cyc();
        chk("single_after_valid", last_rsp_valid, 0);

        // Wrap: pointer sits at 3, requesters 0 and 3 both pending
        glog.delete();
        send(0, 64'h0000_0000_0000_0003, 6'd1, SH_SLL);
        send(3, 64'h0000_0000_0000_0100, 6'd8, SH_SRL);
        drain("wrap_drain");
        chk("wrap_n", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("wrap_first", glog[0], 3);
            chk("wrap_second", glog[1], 0);
        end

        // Arithmetic right shift by the maximum amount
        send(1, 64'hF000_0000_0000_0000, 6'd63, SH_SRA);
        cyc();
        cyc();
        cyc();
        chk("sra_rsp_valid", last_rsp_valid, 4'b0010);
        chk("sra_rsp_data", last_rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        drain("sra_drain");

        // Back-pressure on requester 1 with requester 0 waiting behind it
        rsp_ready = 4'b0001;
        send(1, 64'h0000_0000_0000_00F0, 6'd4, SH_SRL);
        cyc();
        send(0, 64'h0000_0000_0000_0001, 6'd63, SH_SLL);
        for (int t = 0; t < 10 && last_rsp_valid != 4'b0010; t++) cyc();
        chk("bp_rsp_valid_seen", last_rsp_valid, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_data", last_rsp_data, 64'h0000_0000_0000_000F);
            chk("bp_no_ready", last_ready, 0);
            cyc();
        end
        rsp_ready = 4'hF;
        cyc();
        chk("bp_handshake_valid", last_rsp_valid, 4'b0010);
        cyc();
        chk("bp_next_grant", last_ready, 4'b0001);
        chk("bp_valid_dropped", last_rsp_valid, 0);
        drain("bp_drain");

        // Reset while requester 3 is in flight
        send(3, 64'h1234_5678_9ABC_DEF0, 6'd16, SH_ROR);
        cyc();
        chk("rst_accept", last_ready, 4'b1000);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_rsp_valid", last_rsp_valid, 0);
        glog.delete();
        send(0, 64'h0000_0000_FFFF_0000, 6'd16, SH_SRL);
        send(3, 64'h1234_5678_9ABC_DEF0, 6'd16, SH_ROR);
        drain("post_rst_drain");
        chk("post_rst_n", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("post_rst_first", glog[0], 0);
            chk("post_rst_second", glog[1], 3);
        end

        // All four requesters continuously valid
        glog.delete();
        gcyc.delete();
        refill = 4'hF;
        for (int i = 0; i < 4; i++)
            send(i, {$urandom, $urandom}, 6'($urandom_range(0, 63)), shift_op_e'(i));
        repeat (18) cyc();
        refill = '0;
        drain("rr_drain");
        chk("rr_enough", glog.size() >= 5, 1);
        if (glog.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", glog[k], k % 4);
            for (int k = 1; k < 5; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 3);
        end

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
